// File: rtl/controlador_registrador_coluna_pkg.sv
// Shared encodings for the column-register sequencer: FSM states, bank mux
// selects and the user speed-switch codes.
package pkg_registrador_coluna;

  typedef enum logic [1:0] {
    OCIOSO     = 2'b00,
    CARREGANDO = 2'b01,
    DESLOCANDO = 2'b10,
    PAUSADO    = 2'b11
  } estado_t;

  localparam logic [1:0] SEL_CARGA   = 2'b00;
  localparam logic [1:0] SEL_DESLOCA = 2'b01;

  localparam logic [1:0] MODO_ESTATICO = 2'b00;
  localparam logic [1:0] MODO_LENTO    = 2'b01;
  localparam logic [1:0] MODO_MEDIO    = 2'b10;
  localparam logic [1:0] MODO_RAPIDO   = 2'b11;

endpackage

// File: rtl/controlador_registrador_coluna_divisor.sv
// Shift-tick prescaler: counts 0..periodo-1 while enabled and flags the
// terminal count; a count left above a shortened period ticks at once.
module divisor_deslocamento #(
  parameter int LARGURA = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               habilita,
  input  logic               limpa,
  input  logic [LARGURA-1:0] periodo,
  output logic               tick
);

  logic [LARGURA-1:0] contagem_q;
  logic [LARGURA-1:0] contagem_d;

  // ">=" rather than "==" so a speed-up that strands the count past the new
  // terminal value still produces a tick instead of waiting for overflow.
  assign tick = habilita && !limpa && (contagem_q >= (periodo - LARGURA'(1)));

  always_comb begin
    contagem_d = contagem_q;
    if (limpa) begin
      contagem_d = '0;
    end else if (habilita) begin
      contagem_d = tick ? '0 : contagem_q + LARGURA'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      contagem_q <= '0;
    end else begin
      contagem_q <= contagem_d;
    end
  end

endmodule

// File: rtl/controlador_registrador_coluna.sv
// Column-bank sequencer: one-cycle parallel load, then timed circular shifts
// at a switch-selected speed, with pause and back-to-back reload per revolution.
module controlador_registrador_coluna
  import pkg_registrador_coluna::*;
#(
  parameter int DIVISOR     = 8,
  parameter int NUM_COLUNAS = 5
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] chave_modo,
  input  logic       iniciar,
  input  logic       pausar,
  input  logic       carga_pronta,
  output logic       sel_ch1,
  output logic       sel_ch0,
  output logic       habilita_registro,
  output logic       carga_aceita,
  output logic       volta_completa,
  output logic [2:0] deslocamentos,
  output logic       ocupado
);

  localparam int LARGURA = $clog2(DIVISOR) + 1;

  estado_t            estado_q, estado_d;
  logic [1:0]         sel_q, sel_d;
  logic               habilita_q, habilita_d;
  logic               aceita_q, aceita_d;
  logic               volta_q, volta_d;
  logic [2:0]         desl_q, desl_d;
  logic               ocupado_q, ocupado_d;

  logic [LARGURA-1:0] periodo;
  logic               habilita_div;
  logic               limpa_div;
  logic               tick;
  logic               ultima_coluna;

  always_comb begin
    case (chave_modo)
      MODO_MEDIO:  periodo = LARGURA'(DIVISOR / 2);
      MODO_RAPIDO: periodo = LARGURA'(DIVISOR / 4);
      default:     periodo = LARGURA'(DIVISOR);
    endcase
  end

  // Prescaler only advances when the shift branch actually wins priority.
  assign habilita_div  = (estado_q == DESLOCANDO) && (chave_modo != MODO_ESTATICO) && !pausar;
  assign limpa_div     = (estado_q == CARREGANDO);
  assign ultima_coluna = (desl_q == 3'(NUM_COLUNAS - 1));

  divisor_deslocamento #(
    .LARGURA (LARGURA)
  ) u_divisor (
    .clock    (clock),
    .reset_n  (reset_n),
    .habilita (habilita_div),
    .limpa    (limpa_div),
    .periodo  (periodo),
    .tick     (tick)
  );

  always_comb begin
    estado_d   = estado_q;
    sel_d      = sel_q;
    habilita_d = 1'b0;
    aceita_d   = 1'b0;
    volta_d    = 1'b0;
    desl_d     = desl_q;
    ocupado_d  = (estado_q != OCIOSO);

    case (estado_q)
      OCIOSO: begin
        if (iniciar && carga_pronta) begin
          estado_d = CARREGANDO;
        end
      end

      CARREGANDO: begin
        sel_d      = SEL_CARGA;
        habilita_d = 1'b1;
        aceita_d   = 1'b1;
        desl_d     = '0;
        estado_d   = (chave_modo != MODO_ESTATICO) ? DESLOCANDO : OCIOSO;
      end

      DESLOCANDO: begin
        if (chave_modo == MODO_ESTATICO) begin
          estado_d = OCIOSO;
        end else if (pausar) begin
          estado_d = PAUSADO;
        end else if (tick) begin
          sel_d      = SEL_DESLOCA;
          habilita_d = 1'b1;
          if (ultima_coluna) begin
            desl_d  = '0;
            volta_d = 1'b1;
            // Reload chains directly after the revolution's last shift.
            if (carga_pronta) begin
              estado_d = CARREGANDO;
            end
          end else begin
            desl_d = desl_q + 3'd1;
          end
        end
      end

      PAUSADO: begin
        if (chave_modo == MODO_ESTATICO) begin
          estado_d = OCIOSO;
        end else if (!pausar) begin
          estado_d = DESLOCANDO;
        end
      end

      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q   <= OCIOSO;
      sel_q      <= SEL_CARGA;
      habilita_q <= 1'b0;
      aceita_q   <= 1'b0;
      volta_q    <= 1'b0;
      desl_q     <= '0;
      ocupado_q  <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      sel_q      <= sel_d;
      habilita_q <= habilita_d;
      aceita_q   <= aceita_d;
      volta_q    <= volta_d;
      desl_q     <= desl_d;
      ocupado_q  <= ocupado_d;
    end
  end

  assign sel_ch1           = sel_q[1];
  assign sel_ch0           = sel_q[0];
  assign habilita_registro = habilita_q;
  assign carga_aceita      = aceita_q;
  assign volta_completa    = volta_q;
  assign deslocamentos     = desl_q;
  assign ocupado           = ocupado_q;

endmodule
